pkt_mux_nto1: RTL and testbench



---
 rtl/pkt_mux_nto1.sv | 211 +++++++++++++++++++++
 tb/tb_pkt_mux_nto1.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_mux_nto1.sv
// ---------------------------------------------------------------------------
// pkt_mux_nto1 -- N-to-1 wormhole packet multiplexer (NoC router output stage)
//
// A HEAD flit on any input claims the output; the owning port keeps the lock
// until its TAIL flit has been accepted. The output stage is a single
// registered slot with valid/ready backpressure.
//
// Handshake: a flit moves across an interface on a rising edge where both
// valid and ready are high. Valid never depends on ready. The output slot can
// take a new flit whenever it is empty or is being drained in the same cycle
// (slot_free = ~ovalid | oready).
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   idata          NPORT flits, port p at [p*DATAW +: DATAW];
//                  flit type in the top two bits (00 NONE, 01 HEAD,
//                  10 DATA, 11 TAIL)
//   ivalid, ivch   per-port flit valid and virtual-channel id
//   iready         per-port accept (combinational)
//   odata, ovalid, ovch   registered output flit, valid and VC id
//   oready         downstream accept
//   grant          one-hot owner of the current packet, 0 when idle
//   busy           high while a packet holds the lock (state LOCKED)
//
// Optional build macro PKT_MUX_FLIT_CNT_EN adds:
//   flit_cnt [31:0]  output transfers, wraps at 2^32
//   pkt_cnt  [15:0]  output transfers of TAIL flits, wraps at 2^16
// ---------------------------------------------------------------------------
module pkt_mux_nto1 #(
    parameter int NPORT    = 4,
    parameter int DATAW    = 66,
    parameter int VCHW     = 2,
    parameter int ARB_MODE = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NPORT*DATAW-1:0] idata,
    input  logic [NPORT-1:0]       ivalid,
    input  logic [NPORT*VCHW-1:0]  ivch,
    output logic [NPORT-1:0]       iready,
    output logic [DATAW-1:0]       odata,
    output logic                   ovalid,
    output logic [VCHW-1:0]        ovch,
    input  logic                   oready,
    output logic [NPORT-1:0]       grant,
    output logic                   busy
`ifdef PKT_MUX_FLIT_CNT_EN
    ,
    output logic [31:0]            flit_cnt,
    output logic [15:0]            pkt_cnt
`endif
);

    localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam logic [1:0] FT_HEAD = 2'b01;
    localparam logic [1:0] FT_TAIL = 2'b11;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [NPORT-1:0] grant_q, grant_d;
    logic [PW-1:0]    gidx_q, gidx_d;
    logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [DATAW-1:0] odata_q, odata_d;
    logic             ovalid_q, ovalid_d;
    logic [VCHW-1:0]  ovch_q, ovch_d;

    logic             slot_free;
    logic [NPORT-1:0] cand;
    logic             win_found;
    logic [PW-1:0]    win_idx;
    logic [PW-1:0]    arb_base;
    logic [PW-1:0]    sel_idx;
    logic [NPORT-1:0] iready_c;
    logic             in_xfer;
    logic [DATAW-1:0] sel_data;
    logic [VCHW-1:0]  sel_vch;
    logic [1:0]       sel_type;

    // First candidate at or after 'base', wrapping past NPORT-1 to 0.
    // Scanning offsets downward lets the smallest offset win by overwrite.
    function automatic logic [PW:0] pick(input logic [NPORT-1:0] c,
                                         input logic [PW-1:0]    base);
        logic [PW:0] r;
        int          j;
        r = '0;
        for (int i = NPORT - 1; i >= 0; i--) begin
            j = (int'(base) + i) % NPORT;
            if (c[j]) r = {1'b1, j[PW-1:0]};
        end
        return r;
    endfunction

    always_comb begin
        slot_free = ~ovalid_q | oready;
        // Fixed priority is round-robin with the search base pinned at 0.
        arb_base  = (ARB_MODE == 1) ? '0 : rr_ptr_q;

        cand = '0;
        for (int p = 0; p < NPORT; p++) begin
            cand[p] = ivalid[p] & (idata[p*DATAW + DATAW - 2 +: 2] == FT_HEAD);
        end
        {win_found, win_idx} = pick(cand, arb_base);

        // Only one port can ever see iready: the arbitration winner while
        // idle, or the lock owner while locked.
        iready_c = '0;
        sel_idx  = gidx_q;
        if (state_q == ST_IDLE) begin
            sel_idx = win_idx;
            if (win_found && slot_free) iready_c[win_idx] = 1'b1;
        end else begin
            iready_c[gidx_q] = slot_free;
        end

        sel_data = idata[int'(sel_idx)*DATAW +: DATAW];
        sel_vch  = ivch[int'(sel_idx)*VCHW +: VCHW];
        sel_type = sel_data[DATAW-1 -: 2];
        in_xfer  = ivalid[sel_idx] & iready_c[sel_idx];

        state_d  = state_q;
        grant_d  = grant_q;
        gidx_d   = gidx_q;
        rr_ptr_d = rr_ptr_q;
        odata_d  = odata_q;
        ovch_d   = ovch_q;
        ovalid_d = ovalid_q;

        if (in_xfer) begin
            odata_d  = sel_data;
            ovch_d   = sel_vch;
            ovalid_d = 1'b1;
        end else if (oready) begin
            ovalid_d = 1'b0;
        end

        if (in_xfer) begin
            if (state_q == ST_IDLE) begin
                // Only HEAD flits are accepted while idle.
                state_d          = ST_LOCKED;
                gidx_d           = win_idx;
                grant_d          = '0;
                grant_d[win_idx] = 1'b1;
            end else if (sel_type == FT_TAIL) begin
                state_d  = ST_IDLE;
                grant_d  = '0;
                rr_ptr_d = (gidx_q == PW'(NPORT - 1)) ? '0 : gidx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            gidx_q   <= '0;
            rr_ptr_q <= '0;
            odata_q  <= '0;
            ovalid_q <= 1'b0;
            ovch_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gidx_q   <= gidx_d;
            rr_ptr_q <= rr_ptr_d;
            odata_q  <= odata_d;
            ovalid_q <= ovalid_d;
            ovch_q   <= ovch_d;
        end
    end

    assign iready = iready_c;
    assign odata  = odata_q;
    assign ovalid = ovalid_q;
    assign ovch   = ovch_q;
    assign grant  = grant_q;
    assign busy   = (state_q == ST_LOCKED);

`ifdef PKT_MUX_FLIT_CNT_EN
    logic [31:0] flit_cnt_q, flit_cnt_d;
    logic [15:0] pkt_cnt_q, pkt_cnt_d;

    // Counts flits leaving the output register, so a flit is counted once
    // however long it is held by backpressure.
    always_comb begin
        flit_cnt_d = flit_cnt_q;
        pkt_cnt_d  = pkt_cnt_q;
        if (ovalid_q && oready) begin
            flit_cnt_d = flit_cnt_q + 32'd1;
            if (odata_q[DATAW-1 -: 2] == FT_TAIL) pkt_cnt_d = pkt_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flit_cnt_q <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            flit_cnt_q <= flit_cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

    assign flit_cnt = flit_cnt_q;
    assign pkt_cnt  = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_pkt_mux_nto1.sv
// ---------------------------------------------------------------------------
// tb_pkt_mux_nto1 -- directed bench for pkt_mux_nto1
//
// Three instances share one clock and reset:
//   dut_a  NPORT=2, round-robin   (long packet, pointer wrap, counters)
//   dut_b  NPORT=4, round-robin   (simultaneous heads, backpressure, reset)
//   dut_c  NPORT=4, fixed priority
// Flits are {type[1:0], port[2:0], index[4:0]} so every flit is unique.
// ---------------------------------------------------------------------------
module tb_pkt_mux_nto1;

    localparam int DW = 10;
    localparam int VW = 2;
    localparam logic [1:0] FT_NONE = 2'b00;
    localparam logic [1:0] FT_HEAD = 2'b01;
    localparam logic [1:0] FT_DATA = 2'b10;
    localparam logic [1:0] FT_TAIL = 2'b11;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- DUT signals ----------------
    logic [2*DW-1:0] a_idata = '0;
    logic [1:0]      a_ivalid = '0;
    logic [2*VW-1:0] a_ivch = {2'd2, 2'd1};
    logic [1:0]      a_iready;
    logic [DW-1:0]   a_odata;
    logic            a_ovalid;
    logic [VW-1:0]   a_ovch;
    logic            a_oready = 1'b1;
    logic [1:0]      a_grant;
    logic            a_busy;

    logic [4*DW-1:0] b_idata = '0;
    logic [3:0]      b_ivalid = '0;
    logic [4*VW-1:0] b_ivch = {2'd3, 2'd2, 2'd1, 2'd0};
    logic [3:0]      b_iready;
    logic [DW-1:0]   b_odata;
    logic            b_ovalid;
    logic [VW-1:0]   b_ovch;
    logic            b_oready = 1'b1;
    logic [3:0]      b_grant;
    logic            b_busy;

    logic [4*DW-1:0] c_idata = '0;
    logic [3:0]      c_ivalid = '0;
    logic [4*VW-1:0] c_ivch = '0;
    logic [3:0]      c_iready;
    logic [DW-1:0]   c_odata;
    logic            c_ovalid;
    logic [VW-1:0]   c_ovch;
    logic            c_oready = 1'b1;
    logic [3:0]      c_grant;
    logic            c_busy;

`ifdef PKT_MUX_FLIT_CNT_EN
    logic [31:0] a_flit_cnt, b_flit_cnt, c_flit_cnt;
    logic [15:0] a_pkt_cnt, b_pkt_cnt, c_pkt_cnt;
`endif

    pkt_mux_nto1 #(.NPORT(2), .DATAW(DW), .VCHW(VW), .ARB_MODE(0)) dut_a (
        .clk(clk), .rst(rst), .idata(a_idata), .ivalid(a_ivalid), .ivch(a_ivch),
        .iready(a_iready), .odata(a_odata), .ovalid(a_ovalid), .ovch(a_ovch),
        .oready(a_oready), .grant(a_grant), .busy(a_busy)
`ifdef PKT_MUX_FLIT_CNT_EN
        , .flit_cnt(a_flit_cnt), .pkt_cnt(a_pkt_cnt)
`endif
    );

    pkt_mux_nto1 #(.NPORT(4), .DATAW(DW), .VCHW(VW), .ARB_MODE(0)) dut_b (
        .clk(clk), .rst(rst), .idata(b_idata), .ivalid(b_ivalid), .ivch(b_ivch),
        .iready(b_iready), .odata(b_odata), .ovalid(b_ovalid), .ovch(b_ovch),
        .oready(b_oready), .grant(b_grant), .busy(b_busy)
`ifdef PKT_MUX_FLIT_CNT_EN
        , .flit_cnt(b_flit_cnt), .pkt_cnt(b_pkt_cnt)
`endif
    );

    pkt_mux_nto1 #(.NPORT(4), .DATAW(DW), .VCHW(VW), .ARB_MODE(1)) dut_c (
        .clk(clk), .rst(rst), .idata(c_idata), .ivalid(c_ivalid), .ivch(c_ivch),
        .iready(c_iready), .odata(c_odata), .ovalid(c_ovalid), .ovch(c_ovch),
        .oready(c_oready), .grant(c_grant), .busy(c_busy)
`ifdef PKT_MUX_FLIT_CNT_EN
        , .flit_cnt(c_flit_cnt), .pkt_cnt(c_pkt_cnt)
`endif
    );

    // ---------------- scoreboard / checking ----------------
    int checks   = 0;
    int failures = 0;
    logic [DW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input logic [1:0] t, input int p, input int k);
        logic [2:0] pp;
        logic [4:0] kk;
        pp = p[2:0];
        kk = k[4:0];
        return {t, pp, kk};
    endfunction

    // ---------------- arbitration vectors ----------------
    // types holds the flit type of port p in bits [2p+1:2p].
    typedef struct {
        logic [3:0] valid;
        logic [7:0] types;
        logic [3:0] exp_b;   // round-robin
        logic [3:0] exp_c;   // fixed priority
    } arb_vec_t;

    arb_vec_t arb_tab0[8];   // applied with rr_ptr = 0
    arb_vec_t arb_tab3[5];   // applied with dut_b rr_ptr = 3

    task automatic apply_arb(input arb_vec_t v, input string tag);
        @(negedge clk);
        for (int p = 0; p < 4; p++) begin
            b_idata[p*DW +: DW] = mk(v.types[2*p +: 2], p, 0);
            c_idata[p*DW +: DW] = mk(v.types[2*p +: 2], p, 0);
        end
        b_ivalid = v.valid;
        c_ivalid = v.valid;
        #1;
        chk({tag, "_rr"}, b_iready, v.exp_b);
        chk({tag, "_fp"}, c_iready, v.exp_c);
        // Withdrawn before the edge so no flit is actually taken.
        b_ivalid = '0;
        c_ivalid = '0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [3:0]    acc;
        logic          acc1;
        int            ptr[4];
        int            i1;
        int            i3;
        int            idx;
        int            outs;
        int            port;
        int            kk;
        logic [DW-1:0] f;
        logic [3:0]    exp_grant_fp[8];
        logic [3:0]    exp_iready_fp[8];

        arb_tab0[0] = '{4'b0000, 8'h55, 4'b0000, 4'b0000};
        arb_tab0[1] = '{4'b1111, 8'h55, 4'b0001, 4'b0001};
        arb_tab0[2] = '{4'b1110, 8'h55, 4'b0010, 4'b0010};
        arb_tab0[3] = '{4'b1000, 8'h55, 4'b1000, 4'b1000};
        arb_tab0[4] = '{4'b1111, 8'h56, 4'b0010, 4'b0010};  // port 0 DATA
        arb_tab0[5] = '{4'b0100, 8'h30, 4'b0000, 4'b0000};  // port 2 TAIL
        arb_tab0[6] = '{4'b0001, 8'h00, 4'b0000, 4'b0000};  // port 0 NONE
        arb_tab0[7] = '{4'b1010, 8'h55, 4'b0010, 4'b0010};

        arb_tab3[0] = '{4'b1001, 8'h55, 4'b1000, 4'b0001};
        arb_tab3[1] = '{4'b0011, 8'h55, 4'b0001, 4'b0001};  // wrap 3 -> 0
        arb_tab3[2] = '{4'b0110, 8'h55, 4'b0010, 4'b0010};
        arb_tab3[3] = '{4'b1111, 8'h55, 4'b1000, 4'b0001};
        arb_tab3[4] = '{4'b1111, 8'h95, 4'b0001, 4'b0001};  // port 3 DATA

        exp_grant_fp  = '{4'b0010, 4'b0000, 4'b0010, 4'b0000,
                          4'b0010, 4'b0000, 4'b1000, 4'b0000};
        exp_iready_fp = '{4'b0010, 4'b0010, 4'b0010, 4'b0010,
                          4'b0010, 4'b0010, 4'b1000, 4'b1000};

        // ---- reset ----
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_a_ovalid", a_ovalid, 0);
        chk("rst_a_grant",  a_grant,  0);
        chk("rst_a_busy",   a_busy,   0);
        chk("rst_b_ovalid", b_ovalid, 0);
        chk("rst_b_odata",  b_odata,  0);
        chk("rst_b_ovch",   b_ovch,   0);
        chk("rst_b_grant",  b_grant,  0);
        chk("rst_b_busy",   b_busy,   0);
        chk("rst_c_ovalid", c_ovalid, 0);
        chk("rst_c_grant",  c_grant,  0);
`ifdef PKT_MUX_FLIT_CNT_EN
        chk("rst_a_flit_cnt", a_flit_cnt, 0);
        chk("rst_a_pkt_cnt",  a_pkt_cnt,  0);
`endif

        // ---- idle arbitration table ----
        for (int n = 0; n < 8; n++) apply_arb(arb_tab0[n], $sformatf("arb0[%0d]", n));

        // ---- dut_a: port 1 sends HEAD + 20 DATA + TAIL, oready=1 ----
        for (int k = 0; k < 22; k++) begin
            @(negedge clk);
            f = mk((k == 0) ? FT_HEAD : ((k == 21) ? FT_TAIL : FT_DATA), 1, k);
            a_ivalid = 2'b10;
            a_idata  = {f, {DW{1'b0}}};
            #1;
            chk($sformatf("long_iready[%0d]", k), a_iready, 2'b10);
            @(posedge clk);
            #1;
            chk($sformatf("long_odata[%0d]", k), a_odata, f);
            chk($sformatf("long_ovalid[%0d]", k), a_ovalid, 1);
            chk($sformatf("long_grant[%0d]", k), a_grant, (k == 21) ? 2'b00 : 2'b10);
            chk($sformatf("long_busy[%0d]", k), a_busy, (k == 21) ? 1'b0 : 1'b1);
            if (k == 0) chk("long_ovch", a_ovch, 2'd2);
        end
        // Pointer wrapped from port 1 back to 0.
        @(negedge clk);
        a_idata  = {mk(FT_HEAD, 1, 30), mk(FT_HEAD, 0, 30)};
        a_ivalid = 2'b11;
        #1;
        chk("wrap_iready", a_iready, 2'b01);
        a_ivalid = 2'b00;
        @(posedge clk);
        #1;
        chk("long_drain_ovalid", a_ovalid, 0);
        chk("long_drain_grant",  a_grant,  0);

        // ---- dut_b: four simultaneous 3-flit packets ----
        for (int p = 0; p < 4; p++) ptr[p] = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            for (int p = 0; p < 4; p++) begin
                b_ivalid[p] = (ptr[p] < 3);
                b_idata[p*DW +: DW] = mk((ptr[p] == 0) ? FT_HEAD :
                                         ((ptr[p] == 2) ? FT_TAIL : FT_DATA), p, ptr[p]);
            end
            #1;
            acc = b_ivalid & b_iready;
            @(posedge clk);
            #1;
            for (int p = 0; p < 4; p++) if (acc[p]) ptr[p]++;
            port = cyc / 3;
            kk   = cyc % 3;
            f = mk((kk == 0) ? FT_HEAD : ((kk == 2) ? FT_TAIL : FT_DATA), port, kk);
            chk($sformatf("multi_odata[%0d]", cyc), b_odata, f);
            chk($sformatf("multi_ovch[%0d]", cyc), b_ovch, port);
            chk($sformatf("multi_grant[%0d]", cyc), b_grant,
                (kk == 2) ? 4'b0000 : (4'b0001 << port));
            chk($sformatf("multi_busy[%0d]", cyc), b_busy, (kk != 2));
        end
        @(negedge clk);
        b_ivalid = '0;

        // ---- dut_c: fixed priority, ports 1 and 3 hold HEADs ----
        i1 = 0;
        i3 = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            c_ivalid[1] = (i1 < 6);
            c_idata[1*DW +: DW] = mk((i1 % 2 == 1) ? FT_TAIL : FT_HEAD, 1, i1);
            c_ivalid[3] = (i3 < 2);
            c_idata[3*DW +: DW] = mk((i3 == 1) ? FT_TAIL : FT_HEAD, 3, i3);
            #1;
            chk($sformatf("fp_iready[%0d]", cyc), c_iready, exp_iready_fp[cyc]);
            acc = c_ivalid & c_iready;
            @(posedge clk);
            #1;
            if (acc[1]) i1++;
            if (acc[3]) i3++;
            chk($sformatf("fp_grant[%0d]", cyc), c_grant, exp_grant_fp[cyc]);
        end
        @(negedge clk);
        c_ivalid = '0;

        // ---- dut_b: oready low for 5 cycles mid-packet on port 2 ----
        idx  = 0;
        outs = 0;
        exp_q.delete();
        for (int cyc = 0; cyc < 24; cyc++) begin
            @(negedge clk);
            b_oready = (cyc >= 4 && cyc < 9) ? 1'b0 : 1'b1;
            b_ivalid = (idx < 8) ? 4'b0100 : 4'b0000;
            b_idata[2*DW +: DW] = mk((idx == 0) ? FT_HEAD : ((idx == 7) ? FT_TAIL : FT_DATA), 2, idx);
            #1;
            if (!b_oready) begin
                chk($sformatf("bp_ovalid[%0d]", cyc), b_ovalid, 1);
                chk($sformatf("bp_iready[%0d]", cyc), b_iready, 4'b0000);
                chk($sformatf("bp_depth[%0d]", cyc), exp_q.size(), 1);
                if (exp_q.size() > 0) chk($sformatf("bp_hold[%0d]", cyc), b_odata, exp_q[0]);
            end
            if (b_ovalid && b_oready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL bp_extra_out: got %0h expected no output", b_odata);
                end else begin
                    f = exp_q.pop_front();
                    if (b_odata !== f) begin
                        failures++;
                        $display("FAIL bp_odata: got %0h expected %0h", b_odata, f);
                    end
                end
                outs++;
            end
            acc1 = b_ivalid[2] & b_iready[2];
            if (acc1) exp_q.push_back(b_idata[2*DW +: DW]);
            @(posedge clk);
            if (acc1) idx++;
        end
        chk("bp_in_count",  idx,  8);
        chk("bp_out_count", outs, 8);
        chk("bp_leftover",  exp_q.size(), 0);
        @(negedge clk);
        b_ivalid = '0;
        b_oready = 1'b1;

        // ---- idle arbitration with dut_b pointer at 3 ----
        for (int n = 0; n < 5; n++) apply_arb(arb_tab3[n], $sformatf("arb3[%0d]", n));

        // ---- dut_b: reset in the middle of a packet on port 2 ----
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            b_ivalid = 4'b0100;
            b_idata[2*DW +: DW] = mk((k == 0) ? FT_HEAD : FT_DATA, 2, k);
        end
        @(negedge clk);
        rst = 1'b1;
        b_idata[2*DW +: DW] = mk(FT_DATA, 2, 3);
        @(posedge clk);
        #1;
        chk("mrst_ovalid", b_ovalid, 0);
        chk("mrst_grant",  b_grant,  0);
        chk("mrst_busy",   b_busy,   0);
        chk("mrst_odata",  b_odata,  0);
`ifdef PKT_MUX_FLIT_CNT_EN
        chk("mrst_b_flit_cnt", b_flit_cnt, 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            b_idata[2*DW +: DW] = mk(FT_DATA, 2, 4 + k);
            #1;
            chk($sformatf("mrst_data_iready[%0d]", k), b_iready, 4'b0000);
            @(posedge clk);
            #1;
            chk($sformatf("mrst_data_ovalid[%0d]", k), b_ovalid, 0);
            @(negedge clk);
        end
        f = mk(FT_HEAD, 2, 10);
        b_idata[2*DW +: DW] = f;
        #1;
        chk("mrst_head_iready", b_iready, 4'b0100);
        @(posedge clk);
        #1;
        chk("mrst_head_grant", b_grant, 4'b0100);
        chk("mrst_head_odata", b_odata, f);
        @(negedge clk);
        f = mk(FT_TAIL, 2, 11);
        b_idata[2*DW +: DW] = f;
        #1;
        chk("mrst_tail_iready", b_iready, 4'b0100);
        @(posedge clk);
        #1;
        chk("mrst_tail_odata", b_odata, f);
        chk("mrst_tail_busy",  b_busy,  0);
        @(negedge clk);
        b_ivalid = '0;

`ifdef PKT_MUX_FLIT_CNT_EN
        // ---- dut_a counters: 10 packets of 22 flits on port 0 ----
        begin : cnt_test
            int sent;
            int guard;
            sent  = 0;
            guard = 0;
            while (sent < 220 && guard < 600) begin
                @(negedge clk);
                kk = sent % 22;
                a_ivalid = 2'b01;
                a_idata[0 +: DW] = mk((kk == 0) ? FT_HEAD : ((kk == 21) ? FT_TAIL : FT_DATA), 0, kk);
                #1;
                acc1 = a_iready[0];
                @(posedge clk);
                if (acc1) sent++;
                guard++;
            end
            @(negedge clk);
            a_ivalid = 2'b00;
            repeat (2) @(posedge clk);
            #1;
            chk("cnt_sent",     sent,       220);
            chk("cnt_flit_cnt", a_flit_cnt, 220);
            chk("cnt_pkt_cnt",  a_pkt_cnt,  10);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
